program_counter: RTL and testbench

Architectural program-counter register for the single-cycle MIPS datapath. It holds the address of the instruction being fetched and presents it to instruction memory. On every rising clock edge it loads the next-PC value selected upstream (sequential, branch or jump). A synchronous reset returns it to the reset vector. It also provides the sequential successor address (PC + 4) and an optional word-alignment flag.

---
 rtl/program_counter_pkg.sv | 22 ++
 rtl/pc_align_check.sv | 31 +++
 rtl/program_counter.sv | 58 +++++
 tb/tb_program_counter.sv | 111 +++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared widths, reset vector and PC type for the program counter
//
// Constants:
//   PC_WIDTH        - architectural address width in bits
//   PC_RESET_VECTOR - address fetched first after reset
//   INSTR_BYTES     - byte stride between sequential instructions
// Types:
//   pc_t            - one PC_WIDTH-bit address
package program_counter_pkg;

  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  // Sequential successor of an address; unsigned, wraps modulo 2^PC_WIDTH.
  function automatic pc_t next_seq_pc(input pc_t pc);
    return pc + pc_t'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/pc_align_check.sv
// rtl/pc_align_check.sv - word-alignment flag for the PC plus a load-time alignment warning
//
// Instantiated by program_counter only when PC_ALIGN_CHECK_EN is defined.
// Ports:
//   clk           - clock; the warning is evaluated on its rising edge
//   reset         - synchronous active-high reset; suppresses the warning
//   pc_in_low     - low two bits of the value about to be loaded
//   pc_out_low    - low two bits of the current PC
//   pc_misaligned - 1 when the current PC is not a multiple of four
module pc_align_check (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pc_in_low,
  input  logic [1:0] pc_out_low,
  output logic       pc_misaligned
);

  // Pure observation: the stored PC is never altered, only flagged.
  assign pc_misaligned = |pc_out_low;

`ifndef SYNTHESIS
  // Misaligned targets are legal to load, so this only warns.
  property p_aligned_load;
    @(posedge clk) disable iff (reset) (pc_in_low == 2'b00);
  endproperty

  a_aligned_load : assert property (p_aligned_load)
    else $warning("pc_align_check: non-word-aligned PC loaded (low bits %b)", pc_in_low);
`endif

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - architectural PC register with sequential-successor output
//
// Optional feature macro: PC_ALIGN_CHECK_EN (adds pc_misaligned and a load-time warning).
// Parameters:
//   WIDTH        - address width in bits
//   RESET_VECTOR - value loaded on reset, truncated or zero-extended to WIDTH
// Ports:
//   clk           - single clock, all updates on the rising edge
//   reset         - synchronous active-high reset, priority over pc_in
//   pc_in         - next PC selected upstream (sequential, branch or jump)
//   pc_out        - current PC, registered
//   pc_plus4      - pc_out + 4, combinational, wraps modulo 2^WIDTH
//   pc_misaligned - |pc_out[1:0] (PC_ALIGN_CHECK_EN only)
module program_counter
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             pc_misaligned
`endif
);

  // Adapt the package-width vector to WIDTH (truncate or zero-extend).
  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] STRIDE    = WIDTH'(INSTR_BYTES);

  // No enable and no masking: every edge loads pc_in verbatim unless in reset.
  // No initial value is given on purpose; the PC is undefined until first reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out <= RESET_VAL;
    end else begin
      pc_out <= pc_in;
    end
  end

  // Depends only on the register, never on pc_in or reset.
  assign pc_plus4 = pc_out + STRIDE;

`ifdef PC_ALIGN_CHECK_EN
  pc_align_check u_align_check (
    .clk           (clk),
    .reset         (reset),
    .pc_in_low     (pc_in[1:0]),
    .pc_out_low    (pc_out[1:0]),
    .pc_misaligned (pc_misaligned)
  );
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - self-checking bench for program_counter with a reference model
module tb_program_counter;
  import program_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misaligned;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state: the address the architecture says is current.
  longint unsigned model_pc;

  always #10 clk = ~clk;

  program_counter dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .pc_misaligned (pc_misaligned)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Apply inputs for one edge, advance the model, then check at the falling edge.
  task automatic cycle(input logic r, input logic [31:0] v, input string tag);
    longint unsigned succ;
    reset = r;
    pc_in = v;
    @(posedge clk);
    model_pc = r ? longint'(PC_RESET_VECTOR) : longint'(v);
    succ = (model_pc + 4) % 64'h1_0000_0000;
    @(negedge clk);
    check({tag, "_pc"}, pc_out, model_pc[31:0]);
    check({tag, "_plus4"}, pc_plus4, succ[31:0]);
`ifdef PC_ALIGN_CHECK_EN
    check({tag, "_mis"}, {31'b0, pc_misaligned}, {31'b0, (model_pc % 4) != 0});
`endif
  endtask

  initial begin
    logic        r;
    logic [31:0] v;

    @(negedge clk);

    // Reset state
    cycle(1'b1, 32'h0, "reset");

    // Sequential loads, including unaligned values stored verbatim
    cycle(1'b0, 32'h1, "seq1");
    cycle(1'b0, 32'h2, "seq2");
    cycle(1'b0, 32'h3, "seq3");

    // Reset has priority over a held pc_in, then loading resumes
    cycle(1'b1, 32'h3, "rst_prio");
    cycle(1'b0, 32'h10, "resume10");
    cycle(1'b0, 32'h20, "resume20");

    // pc_in changes between edges: output must hold until the edge
    pc_in = 32'h40;
    #4;
    pc_in = 32'h44;
    #2;
    check("midcycle_hold", pc_out, 32'h20);
    cycle(1'b0, 32'h44, "midcycle_edge");

    // Reset pulse that falls entirely between edges is ignored
    pc_in = 32'h50;
    #2 reset = 1'b1;
    #4 reset = 1'b0;
    cycle(1'b0, 32'h50, "glitch_rst");

    // Wrap of the successor address
    cycle(1'b0, 32'hFFFF_FFFC, "wrap");
    cycle(1'b0, 32'hFFFF_FFFF, "wrap_ff");

    // Alignment cases
    cycle(1'b0, 32'h2, "align2");
    cycle(1'b0, 32'h8, "align8");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) == 0);
      v = $urandom;
      if ($urandom_range(0, 3) == 0) v[1:0] = 2'b00;
      cycle(r, v, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
